fpu_norm_arbiter: RTL and testbench
===================================

Name: fpu_norm_arbiter

Overview:
- Shares one 24-bit leading-zero counter and one left shifter between two FPU requesters: requester 0 is the add/sub unit, requester 1 is the int-to-float converter.
- Each requester presents a mantissa and a biased exponent. The block returns the normalised mantissa, the adjusted exponent and status flags.
- Two-stage pipeline with valid/ready handshakes and round-robin arbitration. It sits between the requesters and the rounding stage.

Parameters:
- EXP_WIDTH, 10, width of the biased exponent.
- TAG_WIDTH, 4, width of the opaque tag carried with each request.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, synchronous active-low reset.
- flush, input, 1, synchronous kill of all in-flight operations.
- req_valid, input, 2, request valid; bit i belongs to requester i.
- req_ready, output, 2, request accepted when valid and ready are both 1.
- req_mant_0 / req_mant_1, input, 24, unnormalised mantissa.
- req_exp_0 / req_exp_1, input, EXP_WIDTH, biased exponent (unsigned).
- req_tag_0 / req_tag_1, input, TAG_WIDTH, tag, returned unchanged.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream ready.
- out_mant, output, 24, normalised mantissa.
- out_exp, output, EXP_WIDTH, adjusted exponent.
- out_zero, output, 1, input mantissa was zero.
- out_denorm, output, 1, result is subnormal (exponent clamped to 0).
- out_src, output, 1, index of the requester that issued the result.
- out_tag, output, TAG_WIDTH, tag of the issuing request.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - Both stage valid bits are 0.
  - out_valid=0; out_mant, out_exp, out_tag, out_zero, out_denorm and out_src are all 0.
  - req_ready=2'b00 while reset_n=0.
  - The last-grant register is 1, so requester 0 wins the first conflict.
- Pipeline:
  - Stage S1 registers the granted request together with its LZC result (lz count 0..23 and an all-zero flag).
  - Stage S2 registers the shifted result. S2 drives the out_* ports.
  - Latency is exactly 2 cycles from the req handshake to out_valid when no stall occurs.
  - Throughput is 1 result per cycle.
- Stall rules:
  - S2 loads when it is empty or out_ready=1.
  - S1 loads when it is empty or S2 loads.
  - A full pipeline with out_ready=0 holds every register, holds out_* stable and drives req_ready=2'b00.
- Arbitration:
  - A grant is given only when S1 can load.
  - If exactly one req_valid bit is 1, that requester is granted.
  - If both bits are 1, the requester not granted last time is granted; last-grant updates only on an accepted handshake.
  - req_ready is one-hot or zero: req_ready[i] = grant[i].
  - req_ready may depend combinationally on req_valid and out_ready. No valid may depend on ready.
- Normalisation, computed in S1 to S2 with the exponent E, count lz and mantissa M:
  - Zero mantissa (M=0): out_mant=0, out_exp=0, out_zero=1, out_denorm=0.
  - Normal case (E > lz): out_mant = M << lz, out_exp = E − lz, out_denorm=0.
  - Subnormal case (E ≤ lz, M≠0): the shift amount is E−1 when E≥1 and 0 when E=0. out_mant = M << shift, out_exp=0, out_denorm=1.
  - All exponent arithmetic is unsigned EXP_WIDTH+1 bits; no wrap is allowed.
- Flush:
  - flush=1 clears both stage valid bits at the clock edge and forces req_ready=2'b00 in that cycle, so nothing is accepted.
  - The last-grant register is unchanged.
  - Flush has priority over a concurrent load.
  - reset_n has priority over flush.
- Reset in the middle of an operation drops all in-flight results; no partial result is ever emitted.
- The LZC always operates on the 24-bit mantissa, with bit 23 treated as the MSB.

Test Plan:
- Single request (reset, then req0: M=0x000400, E=100, tag=3) -> 2 cycles later out_valid=1, out_mant=0x800000, out_exp=87, out_src=0, out_tag=3, out_denorm=0.
- Conflict (both requesters valid every cycle with out_ready=1) -> grants alternate 0,1,0,1. Results arrive in order with matching out_src and tags, and one result per cycle.
- Backpressure (fill the pipeline, then out_ready=0 for 5 cycles) -> out_* stable, req_ready=00. Releasing out_ready resumes with no loss or duplication.
- Boundaries:
  - M=0 gives out_zero=1, out_mant=0, out_exp=0.
  - M=0x000001, E=5 gives out_denorm=1, out_mant=0x000010, out_exp=0.
  - M=0x800000, E=1 gives out_mant=0x800000, out_exp=1, out_denorm=0.
- Flush (flush asserted while both stages are full and both requests are valid) -> next cycle out_valid=0 and no handshake occurred in the flush cycle. The following grant still respects round-robin.
- Mid-operation reset (reset_n low for 1 cycle with the pipeline full) -> all outputs return to their reset values and the arbiter grants requester 0 first on the next conflict.

Source files
------------

// File: rtl/fpu_norm_arbiter.sv
// Two-requester normalisation stage: round-robin arbiter in front of one
// 24-bit leading-zero counter and one left shifter, two pipeline stages.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Valids never depend on readies; req_ready may depend
// combinationally on req_valid, out_ready, flush and reset_n.
module fpu_norm_arbiter #(
    parameter int EXP_WIDTH = 10,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [23:0]          req_mant_0,
    input  logic [23:0]          req_mant_1,
    input  logic [EXP_WIDTH-1:0] req_exp_0,
    input  logic [EXP_WIDTH-1:0] req_exp_1,
    input  logic [TAG_WIDTH-1:0] req_tag_0,
    input  logic [TAG_WIDTH-1:0] req_tag_1,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [23:0]          out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_zero,
    output logic                 out_denorm,
    output logic                 out_src,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int EW1 = EXP_WIDTH + 1;

    // S1 registers: granted request plus its LZC result
    logic                 s1_valid;
    logic [23:0]          s1_mant;
    logic [EXP_WIDTH-1:0] s1_exp;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic                 s1_src;
    logic [4:0]           s1_lz;
    logic                 s1_zero;

    // Round-robin state: index of the requester granted most recently
    logic                 last_grant;

    logic                 s2_load;
    logic                 s1_load;
    logic                 can_grant;
    logic [1:0]           grant;

    logic                 sel_src;
    logic [23:0]          sel_mant;
    logic [EXP_WIDTH-1:0] sel_exp;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic [4:0]           sel_lz;
    logic                 sel_zero;

    logic [23:0]          n_mant;
    logic [EXP_WIDTH-1:0] n_exp;
    logic                 n_zero;
    logic                 n_denorm;
    logic [EW1-1:0]       e_ext;
    logic [EW1-1:0]       lz_ext;
    logic [4:0]           shamt;

    assign s2_load   = !out_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign can_grant = s1_load && !flush && reset_n;
    assign req_ready = grant;

    // Arbitration: single requester wins outright, a conflict goes to the one not granted last
    always_comb begin
        grant = 2'b00;
        if (can_grant) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign sel_src  = grant[1];
    assign sel_mant = sel_src ? req_mant_1 : req_mant_0;
    assign sel_exp  = sel_src ? req_exp_1  : req_exp_0;
    assign sel_tag  = sel_src ? req_tag_1  : req_tag_0;
    assign sel_zero = (sel_mant == 24'd0);

    // Leading-zero count of the granted mantissa; the highest set bit is written last
    always_comb begin
        sel_lz = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (sel_mant[i]) sel_lz = 5'(23 - i);
        end
    end

    // S1 register and last-grant update on an accepted handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_mant    <= '0;
            s1_exp     <= '0;
            s1_tag     <= '0;
            s1_src     <= 1'b0;
            s1_lz      <= '0;
            s1_zero    <= 1'b0;
            last_grant <= 1'b1;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= |grant;
            if (|grant) begin
                s1_mant    <= sel_mant;
                s1_exp     <= sel_exp;
                s1_tag     <= sel_tag;
                s1_src     <= sel_src;
                s1_lz      <= sel_lz;
                s1_zero    <= sel_zero;
                last_grant <= sel_src;
            end
        end
    end

    assign e_ext  = EW1'(s1_exp);
    assign lz_ext = EW1'(s1_lz);

    // Normalise: full shift when the exponent can absorb it, otherwise clamp to subnormal
    always_comb begin
        n_mant   = '0;
        n_exp    = '0;
        n_zero   = 1'b0;
        n_denorm = 1'b0;
        shamt    = '0;
        if (s1_zero) begin
            n_zero = 1'b1;
        end else if (e_ext > lz_ext) begin
            n_mant = s1_mant << s1_lz;
            n_exp  = EXP_WIDTH'(e_ext - lz_ext);
        end else begin
            // Here E <= lz <= 23, so E-1 always fits in the shift amount
            shamt    = (s1_exp == '0) ? 5'd0 : 5'(s1_exp - 1'b1);
            n_mant   = s1_mant << shamt;
            n_denorm = 1'b1;
        end
    end

    // S2 register driving the outputs; data only moves when a valid result arrives
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
            out_src    <= 1'b0;
            out_tag    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant   <= n_mant;
                out_exp    <= n_exp;
                out_zero   <= n_zero;
                out_denorm <= n_denorm;
                out_src    <= s1_src;
                out_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_norm_arbiter.sv
// Scoreboard bench for fpu_norm_arbiter: directed vectors with hand-computed
// results, expected values queued on each accepted request, checked by a monitor.
module tb_fpu_norm_arbiter;

    localparam int EW = 10;
    localparam int TW = 4;

    typedef struct packed {
        logic [23:0]   m;
        logic [EW-1:0] e;
        logic [TW-1:0] t;
        logic [40:0]   x;
    } vec_t;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [23:0]   req_mant_0, req_mant_1;
    logic [EW-1:0] req_exp_0, req_exp_1;
    logic [TW-1:0] req_tag_0, req_tag_1;
    logic          out_valid;
    logic          out_ready;
    logic [23:0]   out_mant;
    logic [EW-1:0] out_exp;
    logic          out_zero;
    logic          out_denorm;
    logic          out_src;
    logic [TW-1:0] out_tag;

    vec_t        q0[$];
    vec_t        q1[$];
    logic [40:0] exp_q[$];
    int          n_cmp;
    int          n_fail;
    logic        exp_g;

    fpu_norm_arbiter #(.EXP_WIDTH(EW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mant_0(req_mant_0), .req_mant_1(req_mant_1),
        .req_exp_0(req_exp_0), .req_exp_1(req_exp_1),
        .req_tag_0(req_tag_0), .req_tag_1(req_tag_1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_denorm(out_denorm),
        .out_src(out_src), .out_tag(out_tag)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [40:0] mk(input logic s, input logic [TW-1:0] t, input logic z,
                                       input logic d, input logic [EW-1:0] e, input logic [23:0] m);
        return {s, t, z, d, e, m};
    endfunction

    function automatic vec_t v(input logic [23:0] m, input logic [EW-1:0] e,
                               input logic [TW-1:0] t, input logic [40:0] x);
        vec_t r;
        r.m = m; r.e = e; r.t = t; r.x = x;
        return r;
    endfunction

    function automatic logic [40:0] outs();
        return {out_src, out_tag, out_zero, out_denorm, out_exp, out_mant};
    endfunction

    function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endfunction

    // driver: one cycle; inputs change on negedge, acceptance judged just before posedge
    task automatic step(input logic r, input logic f, input logic o);
        @(negedge clk);
        reset_n    = r;
        flush      = f;
        out_ready  = o;
        req_valid  = {q1.size() > 0, q0.size() > 0};
        req_mant_0 = (q0.size() > 0) ? q0[0].m : '0;
        req_exp_0  = (q0.size() > 0) ? q0[0].e : '0;
        req_tag_0  = (q0.size() > 0) ? q0[0].t : '0;
        req_mant_1 = (q1.size() > 0) ? q1[0].m : '0;
        req_exp_1  = (q1.size() > 0) ? q1[0].e : '0;
        req_tag_1  = (q1.size() > 0) ? q1[0].t : '0;
        #4;
        if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
        if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
    endtask

    task automatic run(input int bound);
        int k;
        k = 0;
        while (k < bound && (q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || out_valid)) begin
            step(1'b1, 1'b0, 1'b1);
            k++;
        end
        cmp("drain_left", 64'(q0.size() + q1.size() + exp_q.size()), 64'd0);
    endtask

    // scoreboard monitor: pop/compare on output transfer, push on request transfer
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset_n !== 1'b1) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        cmp("unexpected_out", {23'd0, outs()}, 64'd0);
                    end else begin
                        cmp("out_result", {23'd0, outs()}, {23'd0, exp_q.pop_front()});
                    end
                end
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (req_valid[0] && req_ready[0]) exp_q.push_back(q0[0].x);
                    if (req_valid[1] && req_ready[1]) exp_q.push_back(q1[0].x);
                end
            end
        end
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 2'b00;
        req_mant_0 = '0; req_mant_1 = '0; req_exp_0 = '0; req_exp_1 = '0;
        req_tag_0 = '0; req_tag_1 = '0;

        // reset state
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        cmp("rst_out_valid", 64'(out_valid), 64'd0);
        cmp("rst_outs", {23'd0, outs()}, 64'd0);
        cmp("rst_req_ready", 64'(req_ready), 64'd0);

        // single request and 2-cycle latency
        q0.push_back(v(24'h000400, 10'd100, 4'd3, mk(1'b0, 4'd3, 1'b0, 1'b0, 10'd87, 24'h800000)));
        step(1'b1, 1'b0, 1'b1);
        cmp("single_grant", 64'(req_ready), 64'b01);
        step(1'b1, 1'b0, 1'b1);
        cmp("single_lat1_valid", 64'(out_valid), 64'd0);
        step(1'b1, 1'b0, 1'b1);
        cmp("single_lat2_valid", 64'(out_valid), 64'd1);
        cmp("single_mant", 64'(out_mant), 64'h800000);
        cmp("single_exp", 64'(out_exp), 64'd87);
        run(10);

        // normalisation boundaries
        q1.push_back(v(24'h000000, 10'd77, 4'd6, mk(1'b1, 4'd6, 1'b1, 1'b0, 10'd0, 24'h000000)));
        q1.push_back(v(24'h000001, 10'd5,  4'd7, mk(1'b1, 4'd7, 1'b0, 1'b1, 10'd0, 24'h000010)));
        q1.push_back(v(24'h000100, 10'd15, 4'd1, mk(1'b1, 4'd1, 1'b0, 1'b1, 10'd0, 24'h400000)));
        q0.push_back(v(24'h800000, 10'd1,  4'd8, mk(1'b0, 4'd8, 1'b0, 1'b0, 10'd1, 24'h800000)));
        q0.push_back(v(24'h000100, 10'd0,  4'd9, mk(1'b0, 4'd9, 1'b0, 1'b1, 10'd0, 24'h000100)));
        q0.push_back(v(24'h000100, 10'd16, 4'd2, mk(1'b0, 4'd2, 1'b0, 1'b0, 10'd1, 24'h800000)));
        run(30);

        // conflict after reset: grants alternate starting with requester 0
        step(1'b0, 1'b0, 1'b1);
        q0.push_back(v(24'h400000, 10'd50,  4'd1, mk(1'b0, 4'd1, 1'b0, 1'b0, 10'd49,  24'h800000)));
        q0.push_back(v(24'h000003, 10'd30,  4'd4, mk(1'b0, 4'd4, 1'b0, 1'b0, 10'd8,   24'hC00000)));
        q1.push_back(v(24'h00FFFF, 10'd200, 4'd2, mk(1'b1, 4'd2, 1'b0, 1'b0, 10'd192, 24'hFFFF00)));
        q1.push_back(v(24'h123456, 10'd10,  4'd5, mk(1'b1, 4'd5, 1'b0, 1'b0, 10'd7,   24'h91A2B0)));
        exp_g = 1'b0;
        for (int k = 0; k < 8 && (q0.size() > 0 || q1.size() > 0); k++) begin
            step(1'b1, 1'b0, 1'b1);
            cmp("rr_onehot", 64'(req_ready != 2'b00), 64'd1);
            if (req_ready != 2'b00) begin
                cmp("rr_grant", 64'(req_ready[1]), 64'(exp_g));
                exp_g = ~exp_g;
            end
        end
        step(1'b1, 1'b0, 1'b1);
        cmp("rr_thru_a", 64'(out_valid), 64'd1);
        step(1'b1, 1'b0, 1'b1);
        cmp("rr_thru_b", 64'(out_valid), 64'd1);
        run(10);

        // backpressure: fill, hold 5 cycles, release
        q0.push_back(v(24'h000800, 10'd40,  4'd10, mk(1'b0, 4'd10, 1'b0, 1'b0, 10'd28,  24'h800000)));
        q0.push_back(v(24'h000001, 10'd100, 4'd12, mk(1'b0, 4'd12, 1'b0, 1'b0, 10'd77,  24'h800000)));
        q1.push_back(v(24'h0F0000, 10'd300, 4'd11, mk(1'b1, 4'd11, 1'b0, 1'b0, 10'd296, 24'hF00000)));
        step(1'b1, 1'b0, 1'b0);
        cmp("bp_grant0", 64'(req_ready), 64'b01);
        step(1'b1, 1'b0, 1'b0);
        cmp("bp_grant1", 64'(req_ready), 64'b10);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0);
            cmp("bp_ready", 64'(req_ready), 64'd0);
            cmp("bp_valid", 64'(out_valid), 64'd1);
            cmp("bp_hold", {23'd0, outs()}, {23'd0, mk(1'b0, 4'd10, 1'b0, 1'b0, 10'd28, 24'h800000)});
        end
        run(20);

        // flush with both stages full and both requests valid
        q0.push_back(v(24'h000010, 10'd60, 4'd1, mk(1'b0, 4'd1, 1'b0, 1'b0, 10'd41, 24'h800000)));
        q0.push_back(v(24'h7FFFFF, 10'd1,  4'd3, mk(1'b0, 4'd3, 1'b0, 1'b1, 10'd0,  24'h7FFFFF)));
        q1.push_back(v(24'h300000, 10'd20, 4'd2, mk(1'b1, 4'd2, 1'b0, 1'b0, 10'd18, 24'hC00000)));
        q1.push_back(v(24'h000002, 10'd2,  4'd4, mk(1'b1, 4'd4, 1'b0, 1'b1, 10'd0,  24'h000004)));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        cmp("flush_no_hs", 64'(req_ready), 64'd0);
        step(1'b1, 1'b0, 1'b1);
        cmp("flush_out_valid", 64'(out_valid), 64'd0);
        cmp("flush_rr_next", 64'(req_ready), 64'b10);
        run(20);

        // reset with the pipeline full, then requester 0 wins the next conflict
        q0.push_back(v(24'h000200, 10'd9,  4'd13, mk(1'b0, 4'd13, 1'b0, 1'b1, 10'd0, 24'h020000)));
        q1.push_back(v(24'h00F000, 10'd12, 4'd14, mk(1'b1, 4'd14, 1'b0, 1'b0, 10'd4, 24'hF00000)));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        cmp("mr_full", 64'(out_valid), 64'd1);
        q0.push_back(v(24'hFFFFFF, 10'd1023, 4'd15, mk(1'b0, 4'd15, 1'b0, 1'b0, 10'd1023, 24'hFFFFFF)));
        q1.push_back(v(24'h000001, 10'd24,   4'd0,  mk(1'b1, 4'd0,  1'b0, 1'b0, 10'd1,    24'h800000)));
        step(1'b0, 1'b0, 1'b1);
        cmp("mr_ready_in_rst", 64'(req_ready), 64'd0);
        step(1'b1, 1'b0, 1'b1);
        cmp("mr_out_valid", 64'(out_valid), 64'd0);
        cmp("mr_outs", {23'd0, outs()}, 64'd0);
        cmp("mr_first_grant", 64'(req_ready), 64'b01);
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
